// File: rtl/ms_es_ordered_bs_by4_gen.sv
// Ordered (thermometer) bitstream encoder.
// Takes one unsigned operand V and streams L = 2^DATA_WIDTH bits, LANES bits
// per beat, earliest bit in lane 0. Bit i of the stream is 1 iff i < V.
module ms_es_ordered_bs_by4_gen #(
    parameter int DATA_WIDTH = 5,
    parameter int LANES      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bin_data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LANES-1:0]      bs_out,
    output logic                  bs_valid,
    input  logic                  bs_ready,
    output logic                  bs_last,
    output logic                  done
);

    localparam int L  = 1 << DATA_WIDTH;
    localparam int NB = L / LANES;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW = $clog2(LANES);
    localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [KW-1:0]         k;
    logic [KW-1:0]         k_n;
    logic [DATA_WIDTH-1:0] opnd;
    logic [DATA_WIDTH-1:0] opnd_n;
    logic                  done_n;
    logic [DATA_WIDTH:0]   base;

    // Next-state logic: operand capture in IDLE, beat advance in STREAM.
    always_comb begin
        state_n = state;
        k_n     = k;
        opnd_n  = opnd;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    opnd_n  = bin_data_in;
                    k_n     = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (bs_valid && bs_ready) begin
                    if (k == K_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered handshake flags; everything holds while en is low.
    // in_ready is a flag rather than a state decode so it stays low in the
    // first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= '0;
            opnd     <= '0;
            in_ready <= 1'b0;
            bs_valid <= 1'b0;
            done     <= 1'b0;
        end else if (en) begin
            state    <= state_n;
            k        <= k_n;
            opnd     <= opnd_n;
            in_ready <= (state_n == IDLE);
            bs_valid <= (state_n == STREAM);
            done     <= done_n;
        end
    end

    // Thermometer beat: lane j is set iff k*LANES + j < V, compared one bit
    // wider than the operand so the position never wraps.
    always_comb begin
        bs_out = '0;
        base   = (DATA_WIDTH + 1)'(k) << LW;
        for (int unsigned j = 0; j < LANES; j++) begin
            bs_out[j] = bs_valid && ((base + (DATA_WIDTH + 1)'(j)) < {1'b0, opnd});
        end
    end

    // Last-beat marker, only meaningful while a beat is presented.
    always_comb begin
        bs_last = bs_valid && (k == K_LAST);
    end

endmodule

// File: tb/tb_ms_es_ordered_bs_by4_gen.sv
// Directed bench for the ordered bitstream encoder (DATA_WIDTH=5, LANES=4).
// Expected beats are hand-computed tables packed 4 bits per beat, beat 0 in
// the low nibble.
module tb_ms_es_ordered_bs_by4_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] bin_data_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bs_out;
    logic       bs_valid;
    logic       bs_ready;
    logic       bs_last;
    logic       done;

    int n_checks;
    int n_errors;

    ms_es_ordered_bs_by4_gen #(
        .DATA_WIDTH(5),
        .LANES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .bin_data_in(bin_data_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .bs_out(bs_out),
        .bs_valid(bs_valid),
        .bs_ready(bs_ready),
        .bs_last(bs_last),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present an operand at a negedge once in_ready is seen; returns at the
    // negedge after the capturing posedge.
    task automatic send_operand(input logic [4:0] v);
        int wait_cyc;
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        bin_data_in = v;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    // Run one full stream. rpat gives bs_ready per cycle; en is dropped for
    // three cycles starting at cycle en_at (negative disables).
    task automatic run_stream(input logic [4:0] v, input logic [31:0] exp,
                              input logic [31:0] rpat, input int en_at);
        int         b;
        int         ones;
        int         cyc;
        logic [3:0] eb;
        logic       rd;
        b    = 0;
        ones = 0;
        cyc  = 0;
        send_operand(v);
        // Operand offered during the stream must be ignored.
        in_valid    = 1'b1;
        bin_data_in = v ^ 5'h1f;
        while (b < 8 && cyc < 64) begin
            eb = exp[b*4 +: 4];
            check("bs_valid", 32'(bs_valid), 32'd1);
            check("bs_out", 32'(bs_out), 32'(eb));
            check("bs_last", 32'(bs_last), (b == 7) ? 32'd1 : 32'd0);
            check("in_ready_busy", 32'(in_ready), 32'd0);
            check("done_busy", 32'(done), 32'd0);
            if (en_at >= 0 && cyc >= en_at && cyc < en_at + 3) en = 1'b0;
            else en = 1'b1;
            rd       = rpat[cyc % 32];
            bs_ready = rd;
            if (rd && en) begin
                ones += $countones(bs_out);
                b++;
                if (b == 8) in_valid = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        en       = 1'b1;
        in_valid = 1'b0;
        check("beat_count", 32'(b), 32'd8);
        check("ones_total", 32'(ones), 32'(v));
        check("done_pulse", 32'(done), 32'd1);
        check("valid_after", 32'(bs_valid), 32'd0);
        check("last_after", 32'(bs_last), 32'd0);
        check("ready_after", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("ready_idle", 32'(in_ready), 32'd1);
        check("valid_idle", 32'(bs_valid), 32'd0);
        bs_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        en          = 1'b1;
        bin_data_in = '0;
        in_valid    = 1'b0;
        bs_ready    = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_bs_valid", 32'(bs_valid), 32'd0);
        check("rst_bs_out", 32'(bs_out), 32'd0);
        check("rst_bs_last", 32'(bs_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rel_in_ready", 32'(in_ready), 32'd0);
        // bs_ready in IDLE has no effect
        bs_ready = 1'b1;
        @(negedge clk);
        check("first_in_ready", 32'(in_ready), 32'd1);
        check("idle_bs_valid", 32'(bs_valid), 32'd0);
        bs_ready = 1'b0;

        run_stream(5'd6,  32'h0000_003F, 32'hFFFF_FFFF, -1);
        run_stream(5'd31, 32'h7FFF_FFFF, 32'hFFFF_FFFF, -1);
        run_stream(5'd0,  32'h0000_0000, 32'hFFFF_FFFF, -1);
        run_stream(5'd13, 32'h0000_1FFF, 32'h9999_9999, -1);
        run_stream(5'd20, 32'h000F_FFFF, 32'hFFFF_FFFF, 3);

        // Asynchronous reset mid-stream at beat 3 of V=20
        send_operand(5'd20);
        bs_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("abort_pre_valid", 32'(bs_valid), 32'd1);
            @(negedge clk);
        end
        check("abort_beat3", 32'(bs_out), 32'hF);
        #2;
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(bs_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_last", 32'(bs_last), 32'd0);
        #1;
        rst      = 1'b1;
        bs_ready = 1'b0;
        @(negedge clk);
        check("abort_done_post", 32'(done), 32'd0);
        check("abort_ready_post", 32'(in_ready), 32'd1);
        run_stream(5'd5, 32'h0000_001F, 32'hFFFF_FFFF, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/ms_es_ordered_bs_by4_gen.md
Name: ms_es_ordered_bs_by4_gen

Overview:
- Binary-to-bitstream encoder for the deterministic stochastic computing (DSC) arch sweep.
- Accepts one unsigned DATA_WIDTH-bit operand and emits its ordered (thermometer) bitstream of length 2^DATA_WIDTH, LANES bits per beat, over a valid/ready stream.
- It is the transmit end of the ordered by-4 bitstream interface that the by-4 multiplier and counter blocks consume.
- Used to drive external stream consumers and as a stimulus source for unit benches.

Parameters:
- DATA_WIDTH, 5, operand width; stream length L = 2^DATA_WIDTH bits.
- LANES, 4, bits per beat. Must be a power of two with LANES <= L. Beats per stream NB = L/LANES (8 at defaults).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  global enable; when 0 all state and outputs hold.
- bin_data_in  input  DATA_WIDTH  unsigned operand V.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- bs_out  output  LANES  current beat; lane 0 is the earliest bit in time.
- bs_valid  output  1  bs_out valid.
- bs_ready  input  1  consumer accepts beat.
- bs_last  output  1  marks beat NB-1.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0, operand reg=0, in_ready=0, bs_valid=0, bs_out=0, bs_last=0, done=0. in_ready rises on the first clock edge after rst is released.
- All register updates are qualified by en=1. With en=0, outputs hold and no handshake completes, even if valid and ready are both high.
- IDLE:
  - in_ready=1, bs_valid=0.
  - On in_valid&in_ready&en: capture V, set k=0, go to STREAM.
  - Beat 0 appears on the next cycle (1-cycle latency).
- STREAM:
  - in_ready=0, bs_valid=1.
  - bs_out[j] = 1 iff k*LANES+j < V, for j = 0..LANES-1. Compare at DATA_WIDTH+1 bits; no wrap.
  - bs_last = (k == NB-1).
  - bs_out and bs_last stay stable while bs_valid=1 and bs_ready=0.
  - On bs_valid&bs_ready&en with k<NB-1: k++.
  - On acceptance of beat NB-1: go to IDLE and pulse done=1 for exactly one cycle, in the cycle after acceptance.
  - in_ready=1 in that same cycle: one bubble between operands, no back-to-back overlap.
- Total ones emitted = V. The final bit of the stream is always 0, because V <= L-1.
- V=0: NB all-zero beats, still fully handshaken.
- in_valid during STREAM is ignored; the operand is not consumed.
- Reset mid-stream aborts immediately. No done pulse; the stream is truncated without bs_last.
- bs_ready high in IDLE has no effect.
- done is registered and is never asserted together with bs_valid.

Test Plan:
- V=6, bs_ready=1 -> bs_out 1111, 0011, then 0000 x6. bs_last only on beat 7. done=1 one cycle after beat 7 accepted. Total 8 beats.
- V=31 -> beats 0..6 = 1111, beat 7 = 0111 with bs_last=1. Ones count = 31.
- V=0 -> 8 beats of 0000, done pulses once, in_ready returns high.
- V=13, bs_ready toggled 1,0,0,1,... -> bs_out/bs_last stable through stalls. Sequence 1111,1111,1111,0001,0000 x4 unchanged by stalls.
- en=0 for 3 cycles mid-stream with bs_ready=1 -> k, bs_out, bs_valid frozen. Stream resumes at the same beat.
- Assert rst=0 asynchronously at beat 3 of V=20 -> bs_valid, done, in_ready drop without a clock edge. After release, a new V=5 gives beats 1111,0001,0000 x6.
